fetch_mem_unit: RTL and testbench

Program-counter, instruction-register and memory-port block sitting directly upstream of the control unit in the 16-bit RISC CPU. It owns PC and IR, executes the CU's pc_ld/pc_inc/pc_sel/ir_ld/adr_sel/mw_en commands, and runs every memory transaction (instruction fetch, LDI immediate, LD, STO) against a variable-latency memory. While a transaction is outstanding it raises `stall`; the sequencer holds state while `stall` is high. A watchdog flags a hung memory.

---
 rtl/fetch_mem_unit.sv | 157 +++++++++++++++
 tb/tb_fetch_mem_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_mem_unit.sv
// Program counter, instruction register and memory port for the 16-bit RISC
// CPU. Runs fetch/immediate/load/store transactions against a variable-latency
// memory, stalls the sequencer while one is outstanding, and flags a hung memory.
module fetch_mem_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ir_ld,
  input  logic        pc_inc,
  input  logic        pc_ld,
  input  logic        pc_sel,
  input  logic        adr_sel,
  input  logic        mw_en,
  input  logic [15:0] R_data,
  input  logic [15:0] W_data,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic [15:0] rd_data,
  output logic [15:0] IR,
  output logic [15:0] PC,
  output logic        stall,
  output logic        fault
);

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FAULT} state_t;
  typedef enum logic [2:0] {K_NOP, K_FETCH, K_STORE, K_LOAD, K_IMM, K_JUMP} kind_t;

  state_t        state, state_nxt;
  kind_t         req_kind, lat_kind, done_kind;
  logic          req_mem, done, start_wait;
  logic [DW-1:0] pc_q, ir_q, lat_addr, lat_wdata, req_addr, req_wdata;
  logic [DW-1:0] jump_off;
  logic [CW-1:0] cnt_q, cnt_nxt;

  assign rd_data  = mem_rdata;
  assign IR       = ir_q;
  assign PC       = pc_q;
  assign jump_off = {{7{ir_q[8]}}, ir_q[8:0]};

  // Classify the CU command set into one request kind, highest priority first
  always_comb begin
    req_kind = K_NOP;
    if (ir_ld)        req_kind = K_FETCH;
    else if (mw_en)   req_kind = K_STORE;
    else if (adr_sel) req_kind = K_LOAD;
    else if (pc_inc)  req_kind = K_IMM;
    else if (pc_ld)   req_kind = K_JUMP;
    req_mem   = (req_kind == K_FETCH) || (req_kind == K_STORE) ||
                (req_kind == K_LOAD)  || (req_kind == K_IMM);
    req_addr  = ((req_kind == K_LOAD) || ((req_kind == K_STORE) && adr_sel)) ? R_data : pc_q;
    req_wdata = (req_kind == K_STORE) ? W_data : '0;
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state, wait counting, memory strobes and completion detection
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt_q;
    done       = 1'b0;
    done_kind  = K_NOP;
    start_wait = 1'b0;
    mem_addr   = pc_q;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_wdata  = '0;
    stall      = 1'b0;
    fault      = 1'b0;
    case (state)
      S_IDLE: begin
        mem_addr  = req_addr;
        mem_rd    = req_mem && (req_kind != K_STORE);
        mem_wr    = (req_kind == K_STORE);
        mem_wdata = req_wdata;
        if (req_mem) begin
          if (mem_ready) begin
            done      = 1'b1;
            done_kind = req_kind;
          end else begin
            stall      = 1'b1;
            start_wait = 1'b1;
            state_nxt  = S_WAIT;
            cnt_nxt    = CW'(1);
          end
        end else if (req_kind == K_JUMP) begin
          done      = 1'b1;
          done_kind = K_JUMP;
        end
      end
      S_WAIT: begin
        mem_addr  = lat_addr;
        mem_rd    = (lat_kind != K_STORE);
        mem_wr    = (lat_kind == K_STORE);
        mem_wdata = lat_wdata;
        if (mem_ready) begin
          done      = 1'b1;
          done_kind = lat_kind;
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else begin
          stall   = 1'b1;
          cnt_nxt = cnt_q + CW'(1);
          if (cnt_nxt == CW'(TIMEOUT)) state_nxt = S_FAULT;
        end
      end
      S_FAULT: begin
        stall = 1'b1;
        fault = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // PC/IR updates on completion; latch the transaction when it must wait
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      cnt_q     <= '0;
      lat_kind  <= K_NOP;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      cnt_q <= cnt_nxt;
      if (start_wait) begin
        lat_kind  <= req_kind;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
      end
      if (done) begin
        case (done_kind)
          K_FETCH: begin
            ir_q <= mem_rdata;
            pc_q <= pc_q + DW'(1);
          end
          K_IMM:   pc_q <= pc_q + DW'(1);
          K_JUMP:  pc_q <= pc_sel ? R_data : pc_q + jump_off;
          default: pc_q <= pc_q;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_mem_unit.sv
// Directed bench for fetch_mem_unit: fetch/jump/store/load/immediate, wait
// states, command priority, reset mid-transaction and watchdog timeout.
module tb_fetch_mem_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        ir_ld, pc_inc, pc_ld, pc_sel, adr_sel, mw_en;
  logic [15:0] R_data, W_data;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, rd_data, IR, PC;
  logic        mem_rd, mem_wr, mem_ready, stall, fault;

  int checks = 0;
  int errors = 0;
  int cnt    = 0;

  fetch_mem_unit #(.RESET_PC(16'h0000), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .ir_ld(ir_ld), .pc_inc(pc_inc), .pc_ld(pc_ld),
    .pc_sel(pc_sel), .adr_sel(adr_sel), .mw_en(mw_en), .R_data(R_data),
    .W_data(W_data), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .rd_data(rd_data), .IR(IR), .PC(PC), .stall(stall), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cu_idle();
    ir_ld = 1'b0; pc_inc = 1'b0; pc_ld = 1'b0; pc_sel = 1'b0;
    adr_sel = 1'b0; mw_en = 1'b0;
  endtask

  task automatic nedge();
    @(negedge clk);
  endtask

  task automatic pedge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; cu_idle();
    mem_ready = 1'b0; mem_rdata = '0; R_data = '0; W_data = '0;
    #12;
    chk("rst_pc", PC, 16'h0000);
    chk("rst_ir", IR, 16'h0000);
    chk("rst_stall", 16'(stall), 16'h0);
    chk("rst_fault", 16'(fault), 16'h0);
    chk("rst_rd", 16'(mem_rd), 16'h0);
    chk("rst_wr", 16'(mem_wr), 16'h0);
    chk("rst_addr", mem_addr, 16'h0000);
    chk("rst_wdata", mem_wdata, 16'h0000);
    nedge(); reset = 1'b1;

    // zero-wait fetch
    nedge(); ir_ld = 1'b1; mem_ready = 1'b1; mem_rdata = 16'hE0C2; #1;
    chk("f0_stall", 16'(stall), 16'h0);
    chk("f0_rd", 16'(mem_rd), 16'h1);
    chk("f0_addr", mem_addr, 16'h0000);
    chk("f0_rd_data", rd_data, 16'hE0C2);
    pedge();
    chk("f0_ir", IR, 16'hE0C2);
    chk("f0_pc", PC, 16'h0001);

    // three-wait fetch from address 0, CU inputs wiggle during wait
    nedge(); cu_idle(); reset = 1'b0;
    nedge(); reset = 1'b1; #1;
    chk("r2_pc", PC, 16'h0000);
    nedge(); ir_ld = 1'b1; mem_ready = 1'b0; mem_rdata = 16'h1111; cnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin ir_ld = 1'b0; pc_ld = 1'b1; end
      #1;
      if (stall) cnt++;
      chk("fw_addr", mem_addr, 16'h0000);
      chk("fw_rd", 16'(mem_rd), 16'h1);
      pedge();
      chk("fw_ir_hold", IR, 16'h0000);
      nedge();
    end
    mem_ready = 1'b1; mem_rdata = 16'hA5A5; #1;
    chk("fw_stall_done", 16'(stall), 16'h0);
    chk("fw_stall_cycles", 16'(cnt), 16'd3);
    pedge();
    chk("fw_ir", IR, 16'hA5A5);
    chk("fw_pc", PC, 16'h0001);

    // jumps and PC wrap
    nedge(); cu_idle(); pc_ld = 1'b1; pc_sel = 1'b1; R_data = 16'h000F; #1;
    chk("j_stall", 16'(stall), 16'h0);
    chk("j_rd", 16'(mem_rd), 16'h0);
    chk("j_wr", 16'(mem_wr), 16'h0);
    pedge();
    chk("j_pc_f", PC, 16'h000F);
    nedge(); cu_idle(); ir_ld = 1'b1; mem_ready = 1'b1; mem_rdata = 16'h01FE;
    pedge();
    chk("j_fetch_pc", PC, 16'h0010);
    chk("j_fetch_ir", IR, 16'h01FE);
    nedge(); cu_idle(); pc_ld = 1'b1; pc_sel = 1'b0;
    pedge();
    chk("j_rel_neg", PC, 16'h000E);
    nedge(); pc_sel = 1'b1; R_data = 16'h1234;
    pedge();
    chk("j_abs", PC, 16'h1234);
    nedge(); R_data = 16'hFFFF;
    pedge();
    chk("j_ffff", PC, 16'hFFFF);
    nedge(); cu_idle(); ir_ld = 1'b1; mem_rdata = 16'h0000; #1;
    chk("wrap_addr", mem_addr, 16'hFFFF);
    pedge();
    chk("wrap_pc", PC, 16'h0000);

    // store with two waits, W_data/R_data change mid-transaction
    nedge(); cu_idle(); mw_en = 1'b1; adr_sel = 1'b1; R_data = 16'h0040;
    W_data = 16'hBEEF; mem_ready = 1'b0; cnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin W_data = 16'h0000; R_data = 16'h0000; mw_en = 1'b0; adr_sel = 1'b0; end
      if (i == 2) mem_ready = 1'b1;
      #1;
      if (mem_wr) cnt++;
      chk("st_addr", mem_addr, 16'h0040);
      chk("st_wdata", mem_wdata, 16'hBEEF);
      chk("st_rd", 16'(mem_rd), 16'h0);
      chk("st_stall", 16'(stall), (i < 2) ? 16'h1 : 16'h0);
      pedge();
      nedge();
    end
    cu_idle(); mem_ready = 1'b0; #1;
    chk("st_wr_cycles", 16'(cnt), 16'd3);
    chk("st_wr_after", 16'(mem_wr), 16'h0);
    chk("st_pc", PC, 16'h0000);

    // zero-wait load and immediate
    nedge(); adr_sel = 1'b1; R_data = 16'h0080; mem_ready = 1'b1; mem_rdata = 16'h2468; #1;
    chk("ld_rd", 16'(mem_rd), 16'h1);
    chk("ld_addr", mem_addr, 16'h0080);
    chk("ld_rd_data", rd_data, 16'h2468);
    pedge();
    chk("ld_pc", PC, 16'h0000);
    chk("ld_ir", IR, 16'h0000);
    nedge(); cu_idle(); pc_inc = 1'b1; #1;
    chk("imm_addr", mem_addr, 16'h0000);
    chk("imm_rd", 16'(mem_rd), 16'h1);
    pedge();
    chk("imm_pc", PC, 16'h0001);

    // ir_ld wins over pc_ld
    nedge(); cu_idle(); ir_ld = 1'b1; pc_ld = 1'b1; pc_sel = 1'b1;
    R_data = 16'h5555; mem_rdata = 16'h1357;
    pedge();
    chk("prio_pc", PC, 16'h0002);
    chk("prio_ir", IR, 16'h1357);

    // reset asserted mid-wait aborts the fetch
    nedge(); cu_idle(); ir_ld = 1'b1; mem_ready = 1'b0; mem_rdata = 16'hFFFF;
    pedge();
    nedge(); #1;
    chk("rw_stall", 16'(stall), 16'h1);
    pedge();
    nedge(); reset = 1'b0; mem_ready = 1'b1; #1;
    chk("rw_pc", PC, 16'h0000);
    chk("rw_ir", IR, 16'h0000);
    chk("rw_stall_rst", 16'(stall), 16'h0);
    pedge();
    chk("rw_ir_hold", IR, 16'h0000);
    nedge(); cu_idle(); reset = 1'b1;
    pedge();
    chk("rw_pc_after", PC, 16'h0000);

    // hung memory trips the watchdog after 16 wait cycles
    nedge(); ir_ld = 1'b1; mem_ready = 1'b0; cnt = 0;
    for (int i = 0; i < 16; i++) begin
      #1;
      if (stall) cnt++;
      chk("to_fault_early", 16'(fault), 16'h0);
      pedge();
      nedge();
    end
    #1;
    chk("to_fault", 16'(fault), 16'h1);
    chk("to_stall", 16'(stall), 16'h1);
    chk("to_rd", 16'(mem_rd), 16'h0);
    chk("to_wr", 16'(mem_wr), 16'h0);
    chk("to_wait_cycles", 16'(cnt), 16'd16);
    mem_ready = 1'b1; mem_rdata = 16'h7777;
    pedge();
    chk("to_sticky", 16'(fault), 16'h1);
    chk("to_pc_frozen", PC, 16'h0000);
    chk("to_ir_frozen", IR, 16'h0000);
    nedge(); cu_idle(); reset = 1'b0; #1;
    chk("to_rst_fault", 16'(fault), 16'h0);
    chk("to_rst_pc", PC, 16'h0000);
    chk("to_rst_stall", 16'(stall), 16'h0);
    nedge(); reset = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
